// File: rtl/rom_word_streamer.sv
// Streams DEPTH words out of a 1-cycle-latency registered-address ROM through a 4-entry FIFO.
// Optional feature: define ROM_STREAM_LOOP_EN for continuous wrap-around streaming with start-as-stop.
module rom_word_streamer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int                    CNT_W     = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(DEPTH - 1);

    logic [1:0]            state;
    logic                  inflight;
    logic [2:0]            fifo_count;
    logic [DATA_WIDTH-1:0] mem [4];
    logic                  issue;
    logic                  pop;
    logic                  last_xfer;
    logic [1:0]            wptr;

    // Occupancy plus the word in flight never exceeds 3, so a push always has room.
    assign issue = (state == FETCH) && ((fifo_count + 3'(inflight)) <= 3'd2);
    assign pop   = data_valid & data_ready;
    assign wptr  = 2'(pop ? fifo_count - 3'd1 : fifo_count);

`ifdef ROM_STREAM_LOOP_EN
    // Run length is open-ended, so the final word is the one that empties the pipe.
    assign last_xfer = (state == DRAIN) && pop && (fifo_count == 3'd1) && !inflight;
`else
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] xfer_cnt;

    assign last_xfer = (state == DRAIN) && pop && (xfer_cnt == LAST_CNT);
`endif

    assign done       = last_xfer;
    assign busy       = (state != IDLE);
    assign data_valid = (fifo_count != 3'd0);
    assign data_out   = mem[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rom_addr <= '0;
            inflight <= 1'b0;
`ifndef ROM_STREAM_LOOP_EN
            issue_cnt <= '0;
            xfer_cnt  <= '0;
`endif
        end else begin
            inflight <= issue;
            if (issue)
                rom_addr <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + 1'b1;
`ifndef ROM_STREAM_LOOP_EN
            if (issue)
                issue_cnt <= issue_cnt + 1'b1;
            if (pop)
                xfer_cnt <= xfer_cnt + 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
`ifndef ROM_STREAM_LOOP_EN
                        issue_cnt <= '0;
                        xfer_cnt  <= '0;
`endif
                    end
                end
                FETCH: begin
`ifdef ROM_STREAM_LOOP_EN
                    if (start)
                        state <= DRAIN;
`else
                    if (issue && issue_cnt == LAST_CNT)
                        state <= DRAIN;
`endif
                end
                DRAIN: begin
                    if (last_xfer) begin
                        state    <= IDLE;
                        rom_addr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift FIFO: mem[0] is the registered head, so data_out only moves on a pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_count <= 3'd0;
            for (int i = 0; i < 4; i++)
                mem[i] <= '0;
        end else begin
            if (pop)
                for (int i = 0; i < 3; i++)
                    mem[i] <= mem[i+1];
            if (inflight)
                mem[wptr] <= rom_data;
            fifo_count <= fifo_count + 3'(inflight) - 3'(pop);
        end
    end
endmodule

// File: tb/tb_rom_word_streamer.sv
// Directed bench for rom_word_streamer: ROM word n = n+1, checks timing, backpressure, reset, DEPTH=1.
module tb_rom_word_streamer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        data_ready = 1'b1;
    logic [3:0]  rom_addr;
    logic [11:0] rom_data;
    logic [11:0] data_out;
    logic        data_valid, busy, done;

    logic        start1 = 1'b0;
    logic [3:0]  rom_addr1;
    logic [11:0] rom_data1;
    logic [11:0] data_out1;
    logic        data_valid1, busy1, done1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Registered-address ROM models, word n holds n+1
    always @(posedge clk) rom_data  <= 12'(rom_addr) + 12'd1;
    always @(posedge clk) rom_data1 <= 12'(rom_addr1) + 12'd1;

    rom_word_streamer #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .done(done)
    );

    rom_word_streamer #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .data_out(data_out1), .data_valid(data_valid1), .data_ready(1'b1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full run from the current negedge; bp_lo..bp_hi is a ready-low window, rnd gives 50% ready.
    task automatic run(input int bp_lo, input int bp_hi, input bit rnd);
        int got = 0;
        int dn = 0;
        logic [3:0] ahead;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            start = (c == 0);
            data_ready = rnd ? 1'($urandom_range(0, 1)) : !(c >= bp_lo && c <= bp_hi);
            #1;
            if (c >= 3 && c >= bp_lo && c <= bp_hi) begin
                chk("bp_valid", data_valid, 1);
                chk("bp_hold", data_out, 1);
            end
            ahead = rom_addr - 4'(got);
            chk("addr_ahead_le3", (ahead <= 4'd3), 1);
            if (data_valid && data_ready) begin
                got++;
                chk("word", data_out, got);
            end
            if (done) begin
                dn++;
                chk("done_on_last", got, 16);
            end
            if (c > 0 && !busy) break;
        end
        chk("run_words", got, 16);
        chk("run_dones", dn, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr", rom_addr, 0);
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst1_valid", data_valid1, 0);
        @(negedge clk);
        reset = 1'b0;

`ifdef ROM_STREAM_LOOP_EN
        begin
            int exp_w = 1;
            int got = 0;
            for (int c = 0; c <= 32; c++) begin
                @(negedge clk);
                start = (c == 0 || c == 25);
                data_ready = 1'b1;
                #1;
                chk("loop_valid", data_valid, (c >= 3 && c <= 27));
                if (data_valid) begin
                    chk("loop_word", data_out, exp_w);
                    exp_w = (exp_w == 16) ? 1 : exp_w + 1;
                    got++;
                end
                chk("loop_done", done, (c == 27));
                if (c == 28) chk("loop_busy_off", busy, 0);
            end
            chk("loop_words", got, 25);
        end
`else
        // Nominal run: words 1..16 in cycles 3..18, done at 18, busy drops at 19
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 0);
            data_ready = 1'b1;
            #1;
            if (c == 1) chk("c1_addr", rom_addr, 0);
            chk("nom_busy", busy, (c >= 1 && c <= 18));
            chk("nom_valid", data_valid, (c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) chk("nom_word", data_out, c - 2);
            chk("nom_done", done, (c == 18));
        end

        run(3, 10, 1'b0);
        repeat (3) run(-1, -1, 1'b1);

        // Reset mid-run at cycle 7
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            start = (c == 0);
            data_ready = 1'b1;
            reset = (c == 7);
            #1;
            if (c == 8) begin
                chk("mrst_valid", data_valid, 0);
                chk("mrst_busy", busy, 0);
                chk("mrst_addr", rom_addr, 0);
                chk("mrst_done", done, 0);
            end
        end
        run(-1, -1, 1'b0);

        // DEPTH=1 with a second start at cycle 2
        begin
            int w = 0;
            int dn = 0;
            for (int c = 0; c <= 9; c++) begin
                @(negedge clk);
                start1 = (c == 0 || c == 2);
                #1;
                if (c == 1) chk("d1_busy", busy1, 1);
                if (c == 3) begin
                    chk("d1_valid", data_valid1, 1);
                    chk("d1_word", data_out1, 1);
                    chk("d1_done", done1, 1);
                end
                if (c == 4) chk("d1_busy_off", busy1, 0);
                if (data_valid1) w++;
                if (done1) dn++;
            end
            chk("d1_words", w, 1);
            chk("d1_dones", dn, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_word_streamer.md
# rom_word_streamer

Sequencer that sits directly upstream of the 12-bit block ROM and turns it into a flow-controlled word stream. On `start` it generates ROM addresses 0..DEPTH-1 and absorbs the ROM's one-cycle registered-address read latency. Returned words are buffered in a 4-entry FIFO so a downstream consumer can apply backpressure without dropping or repeating words. With `data_ready` held high, throughput is one word per cycle.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: ROM address width.
- `DATA_WIDTH`, default 12: ROM word width.
- `DEPTH`, default 16: number of words streamed per run. Legal range is 1..2^ADDR_WIDTH.

Ports:
- `clk` in 1: the block's only clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle run request, sampled only in IDLE.
- `rom_addr` out ADDR_WIDTH: registered address driven to the ROM's `addr` input.
- `rom_data` in DATA_WIDTH: the ROM's `data_out`. It is valid one cycle after `rom_addr` is sampled by the ROM.
- `data_out` out DATA_WIDTH: FIFO head word.
- `data_valid` out 1: `data_out` holds a valid word.
- `data_ready` in 1: consumer accepts the word. A transfer occurs when `data_valid & data_ready`.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse marking the end of a run.

## Operation
- State machine with states IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on `start`.
  - FETCH -> DRAIN when the issue counter reaches DEPTH.
  - DRAIN -> IDLE when the last word transfers. `done` pulses in that same cycle.
- Issue rule: in FETCH, a read issues in a cycle when `fifo_count + inflight <= 2`.
  - `inflight` is 1 if a read was issued in the previous cycle, otherwise 0.
  - When a read issues, `rom_addr` increments at the clock edge and the issue counter increments.
  - The `rom_addr` register holds its value when no read issues.
- Capture: when `inflight` is 1, `rom_data` is pushed into the FIFO in that cycle. The issue rule guarantees the FIFO is never full at a push.
- FIFO: 4 entries with a registered head. Push and pop in the same cycle leave the count unchanged.
- Arithmetic and counters:
  - The issue counter and the transfer counter are ADDR_WIDTH+1 bits wide.
  - `rom_addr` returns to 0 on entry to IDLE.
  - The last word is the transfer with transfer counter = DEPTH-1.
- `start` is ignored while `busy` is high, unless ROM_STREAM_LOOP_EN is defined (see Configuration).
- `reset` mid-run has the following effect at the next edge:
  - state goes to IDLE and the FIFO is flushed;
  - `data_valid`, `busy`, `done` go to 0 and `rom_addr` goes to 0;
  - `inflight` is cleared, so the in-flight ROM word is discarded.
- Reset values: `rom_addr`=0, `data_out`=0, `data_valid`=0, `busy`=0, `done`=0.
- `data_out` is held stable while `data_valid & !data_ready`.

## Timing
- `start` is sampled high in IDLE at cycle 0.
  - Cycle 1: FETCH, `busy`=1, `rom_addr`=0, first read issues.
  - Cycle 2: `rom_data` = word 0 and is pushed.
  - Cycle 3: `data_valid`=1 with `data_out` = word 0.
- Latency from `start` to the first `data_valid` is 3 cycles.
- With `data_ready` held high, the last word transfers in cycle DEPTH+2. `done` pulses in that cycle, `busy` is 1 in that cycle and 0 in the next.
- A new `start` is accepted from the cycle after `done`.
- DEPTH=1: one issue, FETCH->DRAIN at cycle 2, `done` in cycle 3.

## Configuration
- `ROM_STREAM_LOOP_EN` defined:
  - After the issue for address DEPTH-1, issuing continues from address 0 and FETCH never exits on its own.
  - A `start` pulse while busy is a stop request: issuing halts after the current issue, the FIFO drains, and `done` pulses on the final transfer.
- `ROM_STREAM_LOOP_EN` undefined: single-pass behaviour exactly as above, and `start` while busy is ignored.

## Test plan
- Defaults, ROM word n = n+1, `data_ready`=1, `start` at cycle 0:
  - words 1..16 appear on consecutive cycles 3..18;
  - `done` pulses in cycle 18 only;
  - `busy` drops in cycle 19.
- Backpressure: `data_ready`=0 during cycles 3..10, then 1:
  - `data_out` is held at word 1 throughout;
  - no loss or duplication, all 16 words delivered in order;
  - `rom_addr` never advances more than 3 words past the last transfer.
- Random `data_ready` at 50% over 3 runs: every run delivers exactly 16 words and exactly one `done`.
- `reset` asserted at cycle 7 of a run:
  - next cycle: `data_valid`=0, `busy`=0, `rom_addr`=0;
  - a subsequent `start` streams words 1..16 from the beginning.
- DEPTH=1, and `start` pulsed again at cycle 2: exactly one word, `done` at cycle 3, the second `start` is ignored.
- `ROM_STREAM_LOOP_EN` defined, stop pulse at cycle 25:
  - the stream wraps from word 16 to word 1;
  - words stop within 3 cycles of the last issue;
  - `done` pulses with the final transfer.
